ext_trigger_monitor: RTL

Parametrised, multi-channel front-panel trigger monitor in the 40 MHz TTC clock domain. It counts accepted rising edges on up to NCH raw external trigger inputs. Each channel has programmable low-time re-arm (glitch rejection), wrap or saturate counting with sticky overflow, and inter-trigger interval measurement. An atomic all-channel snapshot gives consistent readout; the block sits alongside the processed-trigger path as its diagnostic counterpart.

---
 rtl/ext_trigger_monitor.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ext_trigger_monitor.sv
// ext_trigger_monitor
//
// Diagnostic monitor for raw front-panel triggers in the 40 MHz TTC domain.
// Each of the NCH channels detects rising edges with a programmable low-time
// re-arm that rejects glitches. It counts accepted edges, wrapping or
// saturating, with a sticky overflow flag. It also measures the interval
// between consecutive accepted edges. A snapshot request captures every
// channel's post-update count and interval atomically, so the readout is
// consistent.
//
// Parameters:
//   NCH      number of trigger channels (1..16)
//   CNT_W    trigger counter width per channel
//   DT_W     interval width per channel, in 25 ns ticks
//   MIN_LOW  consecutive low cycles needed before a channel re-arms (1..255)
//   SAT      0 = counters wrap on overflow, 1 = counters hold at all-ones
//
// Ports:
//   ttc_clk                in   40 MHz clock; all logic on its rising edge
//   reset40_n              in   async active-low reset, released synchronously
//   rst_trigger_timestamp  in   sync clear of counts, intervals, overflow, timers
//   ext_trigger            in   NCH raw triggers, already synchronous to ttc_clk
//   chan_enable            in   NCH per-channel count enable
//   snap_req               in   single-cycle snapshot request
//   trig_pulse             out  NCH one-cycle pulse per accepted edge
//   raw_ext_trigger_count  out  live counts, channel i at [i*CNT_W +: CNT_W]
//   ext_trig_delta_t       out  last interval, channel i at [i*DT_W +: DT_W]
//   delta_valid            out  NCH, channel has seen two or more accepted edges
//   overflow               out  NCH sticky counter overflow
//   snap_count             out  snapshot of counts
//   snap_delta             out  snapshot of intervals
//   snap_valid             out  one-cycle pulse when the snapshot updates

module ext_trigger_monitor #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 32,
  parameter int DT_W    = 32,
  parameter int MIN_LOW = 1,
  parameter int SAT     = 0
) (
  input  logic                 ttc_clk,
  input  logic                 reset40_n,
  input  logic                 rst_trigger_timestamp,
  input  logic [NCH-1:0]       ext_trigger,
  input  logic [NCH-1:0]       chan_enable,
  input  logic                 snap_req,
  output logic [NCH-1:0]       trig_pulse,
  output logic [NCH*CNT_W-1:0] raw_ext_trigger_count,
  output logic [NCH*DT_W-1:0]  ext_trig_delta_t,
  output logic [NCH-1:0]       delta_valid,
  output logic [NCH-1:0]       overflow,
  output logic [NCH*CNT_W-1:0] snap_count,
  output logic [NCH*DT_W-1:0]  snap_delta,
  output logic                 snap_valid
);

  localparam int LOW_W = 8;
  localparam logic [LOW_W-1:0] MIN_LOW_V = LOW_W'(MIN_LOW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    REARM = 2'd2
  } state_t;

  // Reset synchroniser: reset40_n clears the whole block immediately.
  // Release is retimed through two flops so that every register leaves
  // reset on the same ttc_clk edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge ttc_clk or negedge reset40_n) begin
    if (!reset40_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // Post-update values of every channel for this cycle. These feed the
  // snapshot registers, so a snapshot equals what the live outputs show
  // one cycle later.
  logic [NCH*CNT_W-1:0] count_next;
  logic [NCH*DT_W-1:0]  delta_next;

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    logic             trig_in;
    state_t           state_q;
    state_t           state_d;
    logic [LOW_W-1:0] low_cnt_q;
    logic [LOW_W-1:0] low_cnt_d;
    logic             armed_q;
    logic             edge_ev;
    logic             accept;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DT_W-1:0]  dt_q;
    logic [DT_W-1:0]  dt_d;
    logic [DT_W-1:0]  tmr_q;
    logic [DT_W-1:0]  tmr_d;
    logic             first_q;
    logic             first_d;
    logic             dv_q;
    logic             dv_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             pulse_q;

    assign trig_in = ext_trigger[i];
    assign accept  = edge_ev & chan_enable[i];

    // armed_q is clear after reset until the input has been seen low.
    // A trigger that is already high when reset releases therefore lands
    // in HIGH without producing an edge. It only counts once the input
    // has gone low and then high again.
    always_ff @(posedge ttc_clk or negedge rst_n) begin
      if (!rst_n) begin
        armed_q <= 1'b0;
      end else if (!trig_in) begin
        armed_q <= 1'b1;
      end
    end

    // Edge detector state register.
    always_ff @(posedge ttc_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        low_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        low_cnt_q <= low_cnt_d;
      end
    end

    // Edge detector next state. An edge is reported only when leaving IDLE.
    // A high seen while in REARM is treated as a glitch: the FSM follows
    // the level back to HIGH, but no edge is reported.
    always_comb begin
      state_d   = state_q;
      low_cnt_d = low_cnt_q;
      edge_ev   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trig_in) begin
            state_d = HIGH;
            edge_ev = armed_q;
          end
        end
        HIGH: begin
          if (!trig_in) begin
            if (MIN_LOW <= 1) begin
              state_d = IDLE;
            end else begin
              state_d   = REARM;
              low_cnt_d = LOW_W'(1);
            end
          end
        end
        REARM: begin
          if (trig_in) begin
            state_d   = HIGH;
            low_cnt_d = '0;
          end else if (low_cnt_q + 1'b1 == MIN_LOW_V) begin
            state_d   = IDLE;
            low_cnt_d = '0;
          end else begin
            low_cnt_d = low_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          low_cnt_d = '0;
        end
      endcase
    end

    // Counter, interval and timer update.
    // The timer runs every cycle and saturates. An accepted edge reloads
    // it to 1, so when the next accepted edge arrives the timer holds the
    // exact cycle distance between the two edges. The synchronous clear
    // takes priority over a coincident edge. That edge is not counted,
    // although its pulse is still emitted.
    always_comb begin
      cnt_d   = cnt_q;
      dt_d    = dt_q;
      tmr_d   = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
      first_d = first_q;
      dv_d    = dv_q;
      ovf_d   = ovf_q;
      if (rst_trigger_timestamp) begin
        cnt_d   = '0;
        dt_d    = '0;
        tmr_d   = '0;
        first_d = 1'b0;
        dv_d    = 1'b0;
        ovf_d   = 1'b0;
      end else if (accept) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = (SAT != 0) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        tmr_d   = DT_W'(1);
        first_d = 1'b1;
        if (first_q) begin
          dt_d = tmr_q;
          dv_d = 1'b1;
        end
      end
    end

    // Per-channel datapath registers.
    always_ff @(posedge ttc_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        dt_q    <= '0;
        tmr_q   <= '0;
        first_q <= 1'b0;
        dv_q    <= 1'b0;
        ovf_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        dt_q    <= dt_d;
        tmr_q   <= tmr_d;
        first_q <= first_d;
        dv_q    <= dv_d;
        ovf_q   <= ovf_d;
        pulse_q <= accept;
      end
    end

    assign trig_pulse[i]                           = pulse_q;
    assign raw_ext_trigger_count[i*CNT_W +: CNT_W] = cnt_q;
    assign ext_trig_delta_t[i*DT_W +: DT_W]        = dt_q;
    assign delta_valid[i]                          = dv_q;
    assign overflow[i]                             = ovf_q;
    assign count_next[i*CNT_W +: CNT_W]            = cnt_d;
    assign delta_next[i*DT_W +: DT_W]              = dt_d;
  end

  // Snapshot registers. All channels load from their next-state values in
  // the same cycle, so the capture is atomic across the whole block.
  // A request that coincides with the synchronous clear captures zeros.
  always_ff @(posedge ttc_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_count <= '0;
      snap_delta <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_count <= count_next;
        snap_delta <= delta_next;
      end
    end
  end

endmodule
